// File: rtl/register_bank_8088_ctx_if.sv
// Bus bundle for the 8088-style register bank: write port, two read ports, context-transfer control.
// The master drives requests and indices; the slave (the bank) returns read data and status.
interface register_bank_8088_ctx_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              en_write;
    logic [ADDR_W-1:0] reg_write;
    logic [DATA_W-1:0] write_data;
    logic              size;
    logic              select_high_low;
    logic [ADDR_W-1:0] reg_read1;
    logic [ADDR_W-1:0] reg_read2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              ctx_start;
    logic              ctx_dir;
    logic              ctx_busy;
    logic              ctx_done;
    logic              write_dropped;

    modport master (
        output en_write, reg_write, write_data, size, select_high_low,
               reg_read1, reg_read2, ctx_start, ctx_dir,
        input  read_data1, read_data2, ctx_busy, ctx_done, write_dropped
    );

    modport slave (
        input  en_write, reg_write, write_data, size, select_high_low,
               reg_read1, reg_read2, ctx_start, ctx_dir,
        output read_data1, read_data2, ctx_busy, ctx_done, write_dropped
    );
endinterface

// File: rtl/register_bank_8088_ctx.sv
// General-purpose register bank with lane writes, two async read ports and a
// shadow bank filled/emptied one register per clock by a save/restore sequencer.
module register_bank_8088_ctx #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    register_bank_8088_ctx_if.slave bus
);
    localparam int HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] main_q   [NUM_REGS];
    logic [DATA_W-1:0] main_d   [NUM_REGS];
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];

    logic              busy;
    logic              wr_acc;
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] rd1, rd2;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] data,
        input logic              full,
        input logic              high
    );
        if (full)      return data;
        else if (high) return {data[HALF_W-1:0], old_val[HALF_W-1:0]};
        else           return {old_val[DATA_W-1:HALF_W], data[HALF_W-1:0]};
    endfunction

    assign busy   = (state_q != S_IDLE);
    assign wr_acc = bus.en_write & ~busy;
    assign wr_val = lane_merge(main_q[bus.reg_write], bus.write_data,
                               bus.size, bus.select_high_low);

    // Forwarding is suppressed under reset so the read ports show the cleared bank.
    always_comb begin
        rd1 = main_q[bus.reg_read1];
        rd2 = main_q[bus.reg_read2];
        if (BYPASS != 0 && wr_acc && !reset) begin
            if (bus.reg_write == bus.reg_read1) rd1 = wr_val;
            if (bus.reg_write == bus.reg_read2) rd2 = wr_val;
        end
    end

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        main_d   = main_q;
        shadow_d = shadow_q;

        if (wr_acc) main_d[bus.reg_write] = wr_val;

        unique case (state_q)
            S_IDLE: begin
                if (bus.ctx_start) begin
                    dir_d   = bus.ctx_dir;
                    idx_d   = '0;
                    state_d = S_COPY;
                end
            end
            S_COPY: begin
                if (dir_q) main_d[idx_q]   = shadow_q[idx_q];
                else       shadow_d[idx_q] = main_q[idx_q];
                if (idx_q == ADDR_W'(NUM_REGS - 1)) state_d = S_DONE;
                else                                idx_d   = idx_q + ADDR_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: both banks are reset explicitly because a mid-transfer reset must leave them all-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                main_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            main_q   <= main_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.read_data1    = rd1;
    assign bus.read_data2    = rd2;
    assign bus.ctx_busy      = busy;
    assign bus.ctx_done      = (state_q == S_DONE);
    assign bus.write_dropped = bus.en_write & busy;

endmodule

// File: tb/tb_register_bank_8088_ctx.sv
// Scoreboard bench for register_bank_8088_ctx: a reference model of both banks
// predicts every read and the context-transfer timing.
module tb_register_bank_8088_ctx;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int BYPASS   = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_bank_8088_ctx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    register_bank_8088_ctx #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] model_main   [NUM_REGS];
    logic [DATA_W-1:0] model_shadow [NUM_REGS];
    logic [DATA_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_val, input logic [15:0] d,
                                          input logic sz, input logic sel);
        if (sz)       return d;
        else if (sel) return {d[7:0], old_val[7:0]};
        else          return {old_val[15:8], d[7:0]};
    endfunction

    task automatic idle_inputs();
        bus.en_write        = 1'b0;
        bus.reg_write       = '0;
        bus.write_data      = '0;
        bus.size            = 1'b1;
        bus.select_high_low = 1'b0;
        bus.reg_read1       = '0;
        bus.reg_read2       = '0;
        bus.ctx_start       = 1'b0;
        bus.ctx_dir         = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) begin
            model_main[i]   = '0;
            model_shadow[i] = '0;
        end
    endtask

    // Called just after a falling edge; the write lands on the following rising edge.
    task automatic write_reg(input int a, input logic [15:0] d, input logic sz, input logic sel);
        bus.en_write        = 1'b1;
        bus.reg_write       = ADDR_W'(a);
        bus.write_data      = d;
        bus.size            = sz;
        bus.select_high_low = sel;
        model_main[a]       = merge(model_main[a], d, sz, sel);
        @(negedge clk);
        bus.en_write = 1'b0;
    endtask

    task automatic check_reads(input string tag, input int a, input int b);
        bus.reg_read1 = ADDR_W'(a);
        bus.reg_read2 = ADDR_W'(b);
        exp_q.push_back(model_main[a]);
        exp_q.push_back(model_main[b]);
        #1;
        check({tag, "/rd1"}, 32'(bus.read_data1), 32'(exp_q.pop_front()));
        check({tag, "/rd2"}, 32'(bus.read_data2), 32'(exp_q.pop_front()));
    endtask

    task automatic start_ctx(input logic dir);
        bus.ctx_start = 1'b1;
        bus.ctx_dir   = dir;
        @(negedge clk);
        bus.ctx_start = 1'b0;
    endtask

    // Entered at the first falling edge after the start edge; watches a fixed window.
    task automatic observe_ctx(input string tag, input logic dir, input bit disturb);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = 0;
        for (int c = 1; c <= 12; c++) begin
            if (disturb && c == 3) begin
                bus.en_write   = 1'b1;
                bus.reg_write  = 3'd3;
                bus.write_data = 16'hBEEF;
                bus.size       = 1'b1;
                bus.ctx_start  = 1'b1;
                bus.ctx_dir    = ~dir;
                bus.reg_read1  = 3'd3;
                exp_q.push_back(model_main[3]);
            end
            #1;
            if (disturb && c == 3) begin
                check({tag, "/write_dropped"}, 32'(bus.write_dropped), 1);
                check({tag, "/reg3_no_bypass"}, 32'(bus.read_data1), 32'(exp_q.pop_front()));
            end
            if (bus.ctx_busy) busy_n++;
            if (bus.ctx_done) begin
                done_n++;
                done_at = c;
            end
            @(negedge clk);
            bus.en_write  = 1'b0;
            bus.ctx_start = 1'b0;
        end
        check({tag, "/busy_cycles"}, busy_n, NUM_REGS + 1);
        check({tag, "/done_pulses"}, done_n, 1);
        check({tag, "/done_cycle"}, done_at, NUM_REGS + 1);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dir) model_main[i]   = model_shadow[i];
            else     model_shadow[i] = model_main[i];
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NUM_REGS; i += 2) check_reads(tag, i, i + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        idle_inputs();
        clear_model();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset: outputs quiet, forwarding gated even with a write request present.
        bus.en_write   = 1'b1;
        bus.reg_write  = 3'd0;
        bus.write_data = 16'h5555;
        bus.reg_read1  = 3'd0;
        #1;
        check("rst/bypass_gated", 32'(bus.read_data1), 0);
        check("rst/busy", 32'(bus.ctx_busy), 0);
        check("rst/done", 32'(bus.ctx_done), 0);
        check("rst/dropped", 32'(bus.write_dropped), 0);
        bus.en_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_reads("rst/bank", 0, 7);

        // Full-word write and read-back.
        write_reg(0, 16'hABCD, 1'b1, 1'b0);
        check_reads("t1", 0, 0);

        // Half-word lanes.
        write_reg(1, 16'h00EF, 1'b0, 1'b0);
        write_reg(1, 16'h0012, 1'b0, 1'b1);
        check_reads("t2", 1, 0);

        // Same-cycle read of the register being written.
        bus.en_write   = 1'b1;
        bus.reg_write  = 3'd2;
        bus.write_data = 16'h3456;
        bus.size       = 1'b1;
        bus.reg_read1  = 3'd2;
        bus.reg_read2  = 3'd1;
        exp_q.push_back((BYPASS != 0) ? 16'h3456 : model_main[2]);
        exp_q.push_back(model_main[1]);
        #1;
        check("t3/bypass_rd1", 32'(bus.read_data1), 32'(exp_q.pop_front()));
        check("t3/other_rd2", 32'(bus.read_data2), 32'(exp_q.pop_front()));
        model_main[2] = 16'h3456;
        @(negedge clk);
        bus.en_write = 1'b0;
        check_reads("t3/after_edge", 2, 2);

        // Lane-merged forwarding on port 2.
        bus.en_write        = 1'b1;
        bus.reg_write       = 3'd1;
        bus.write_data      = 16'h0077;
        bus.size            = 1'b0;
        bus.select_high_low = 1'b1;
        bus.reg_read1       = 3'd0;
        bus.reg_read2       = 3'd1;
        exp_q.push_back(model_main[0]);
        exp_q.push_back((BYPASS != 0) ? merge(model_main[1], 16'h0077, 1'b0, 1'b1) : model_main[1]);
        #1;
        check("t3/lane_rd1", 32'(bus.read_data1), 32'(exp_q.pop_front()));
        check("t3/lane_rd2", 32'(bus.read_data2), 32'(exp_q.pop_front()));
        model_main[1] = merge(model_main[1], 16'h0077, 1'b0, 1'b1);
        @(negedge clk);
        bus.en_write = 1'b0;
        check_reads("t3/lane_after", 1, 1);

        // Load the bank; the last write shares its cycle with the save start.
        for (int i = 0; i < NUM_REGS - 1; i++) write_reg(i, 16'(16'h1000 + i), 1'b1, 1'b0);
        bus.en_write   = 1'b1;
        bus.reg_write  = 3'd7;
        bus.write_data = 16'h1007;
        bus.size       = 1'b1;
        model_main[7]  = 16'h1007;
        start_ctx(1'b0);
        bus.en_write = 1'b0;
        observe_ctx("t4/save", 1'b0, 1'b0);
        check_all("t4/after_save");

        write_reg(0, 16'h1111, 1'b1, 1'b0);
        write_reg(7, 16'h7777, 1'b1, 1'b0);
        check_reads("t4/dirty", 0, 7);
        start_ctx(1'b1);
        observe_ctx("t4/restore", 1'b1, 1'b0);
        check_all("t4/after_restore");

        // Write and second start during COPY are both ignored.
        start_ctx(1'b0);
        observe_ctx("t5/save", 1'b0, 1'b1);
        #1;
        check("t5/dropped_clear", 32'(bus.write_dropped), 0);
        check("t5/busy_clear", 32'(bus.ctx_busy), 0);
        check_reads("t5/reg3", 3, 4);

        // Reset while idx=3 of a save.
        start_ctx(1'b0);
        done_n = 0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            if (bus.ctx_done) done_n++;
            @(negedge clk);
        end
        reset         = 1'b1;
        bus.reg_read1 = 3'd0;
        bus.reg_read2 = 3'd5;
        #1;
        clear_model();
        check("t6/busy_abort", 32'(bus.ctx_busy), 0);
        check("t6/rd1_zero", 32'(bus.read_data1), 0);
        check("t6/rd2_zero", 32'(bus.read_data2), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (bus.ctx_done) done_n++;
            @(negedge clk);
        end
        check("t6/no_done", done_n, 0);
        start_ctx(1'b1);
        observe_ctx("t6/restore", 1'b1, 1'b0);
        check_all("t6/zeros");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
